// File: rtl/datapath_sequencer_pkg.sv
// Shared types and encodings for the SimpleRISC datapath sequencer:
// FSM states, instruction classes, opcode/op fields and datapath control codes.
package sequencer_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_LDA,
    S_LDB,
    S_EXEC,
    S_WB,
    S_WIMM
  } state_e;

  typedef enum logic [2:0] {
    CLS_MOVIMM,
    CLS_MOVREG,
    CLS_ALU,
    CLS_CMP,
    CLS_MVN,
    CLS_ILLEGAL
  } iclass_e;

  localparam logic [2:0] OPC_MOV   = 3'b110;
  localparam logic [2:0] OPC_ALU   = 3'b101;
  localparam logic [1:0] OP_MOVIMM = 2'b10;
  localparam logic [1:0] OP_MOVREG = 2'b00;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/datapath_sequencer_instr_decoder.sv
// Combinational decode of the instruction register: register fields,
// sign-extended immediates and the instruction class that steers the FSM.
module instr_decoder
  import sequencer_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output iclass_e     iclass
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  always_comb begin
    iclass = CLS_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOVIMM)      iclass = CLS_MOVIMM;
      else if (op == OP_MOVREG) iclass = CLS_MOVREG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        ALU_CMP: iclass = CLS_CMP;
        ALU_MVN: iclass = CLS_MVN;
        default: iclass = CLS_ALU;
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Moore FSM that walks the SimpleRISC datapath through one instruction at a
// time: operand loads, ALU execute and register writeback.
module datapath_sequencer
  import sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  op, sh;
  logic [2:0]  rn, rd, rm;
  iclass_e     iclass;

  instr_decoder u_dec (
    .ir     (ir_q),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .iclass (iclass)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: if (s) begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          CLS_MOVIMM:         state_d = S_WIMM;
          CLS_MOVREG, CLS_MVN: state_d = S_LDB;
          CLS_ALU, CLS_CMP:   state_d = S_LDA;
          default:            state_d = S_WAIT;
        endcase
      end
      S_LDA:  state_d = S_LDB;
      S_LDB:  state_d = S_EXEC;
      S_EXEC: state_d = (iclass == CLS_CMP) ? S_WAIT : S_WB;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    illegal  = 1'b0;
    readnum  = rn;
    writenum = rn;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_DECODE: illegal = (iclass == CLS_ILLEGAL);
      S_LDA:    loada = 1'b1;
      S_LDB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        asel  = (iclass == CLS_MOVREG) || (iclass == CLS_MVN);
        shift = sh;
        ALUop = (iclass == CLS_MOVREG) ? ALU_ADD : op;
        if (iclass == CLS_CMP) loads = 1'b1;
        else                   loadc = 1'b1;
      end
      S_WB: begin
        writenum = rd;
        write    = 1'b1;
      end
      S_WIMM: begin
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      default: ;
    endcase
    // Reset kills every strobe immediately so a reset landing in WB/WIMM never writes.
    if (reset) begin
      write   = 1'b0;
      loada   = 1'b0;
      loadb   = 1'b0;
      loadc   = 1'b0;
      loads   = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule
